// File: rtl/block_mem_ctrl.sv
// Block memory controller: services 1024-bit refill/writeback requests from the
// data cache against a word-wide, fixed-latency memory. Optional macro: BLOCK_MEM_CTRL_STATS_EN.
module block_mem_ctrl #(
   parameter int MEM_LAT = 4,
   parameter int NWORDS  = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    req_op,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wb_addr,
   input  logic [1023:0] req_wdata,
   output logic          resp_valid,
   output logic [1023:0] resp_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [31:0]   mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
`ifdef BLOCK_MEM_CTRL_STATS_EN
   ,
   output logic [15:0]   stat_refills,
   output logic [15:0]   stat_writebacks
`endif
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WB       = 3'd1;
   localparam logic [2:0] S_RD_ISSUE = 3'd2;
   localparam logic [2:0] S_RD_WAIT  = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   localparam logic [1:0] OP_WB    = 2'b01;
   localparam logic [1:0] OP_WB_RD = 2'b10;

   localparam logic [4:0] IDX_LAST = 5'(NWORDS - 1);
   localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

   logic [2:0]    state;
   logic [4:0]    idx;
   logic [3:0]    lat_cnt;
   logic [1:0]    op_q;
   logic [24:0]   rd_blk;
   logic [24:0]   wb_blk;
   logic [1023:0] wdata_q;
   logic          accept;
   logic          rd_capture;

   // Block offset bits of both addresses are don't-care.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{req_addr[6:0], req_wb_addr[6:0]};

   assign accept     = (state == S_IDLE) && req_valid;
   assign rd_capture = (state == S_RD_WAIT) && (lat_cnt == LAT_LAST);
   assign req_ready  = (state == S_IDLE);
   assign resp_valid = (state == S_DONE);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         idx        <= '0;
         lat_cnt    <= '0;
         op_q       <= '0;
         rd_blk     <= '0;
         wb_blk     <= '0;
         resp_rdata <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op_q    <= req_op;
                  rd_blk  <= req_addr[31:7];
                  wb_blk  <= req_wb_addr[31:7];
                  idx     <= '0;
                  lat_cnt <= '0;
                  state   <= (req_op == OP_WB || req_op == OP_WB_RD) ? S_WB : S_RD_ISSUE;
               end
            end
            S_WB: begin
               if (idx == IDX_LAST) begin
                  idx   <= '0;
                  state <= (op_q == OP_WB_RD) ? S_RD_ISSUE : S_DONE;
               end else begin
                  idx <= idx + 5'd1;
               end
            end
            S_RD_ISSUE: begin
               lat_cnt <= '0;
               state   <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               if (rd_capture) begin
                  resp_rdata[{idx, 5'b0} +: 32] <= mem_rdata;
                  if (idx == IDX_LAST) begin
                     state <= S_DONE;
                  end else begin
                     idx   <= idx + 5'd1;
                     state <= S_RD_ISSUE;
                  end
               end else begin
                  lat_cnt <= lat_cnt + 4'd1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // NOTE: pure data register, always loaded before it is read, so it carries no reset.
   always_ff @(posedge clk) begin
      if (accept) wdata_q <= req_wdata;
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         S_WB: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {wb_blk, idx, 2'b00};
            mem_wdata = wdata_q[{idx, 5'b0} +: 32];
         end
         S_RD_ISSUE: begin
            mem_en   = 1'b1;
            mem_addr = {rd_blk, idx, 2'b00};
         end
         default: ;
      endcase
   end

`ifdef BLOCK_MEM_CTRL_STATS_EN
   logic enter_done;
   assign enter_done = (state == S_WB && idx == IDX_LAST && op_q == OP_WB) ||
                       (rd_capture && idx == IDX_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_refills    <= '0;
         stat_writebacks <= '0;
      end else if (enter_done) begin
         if (op_q != OP_WB && stat_refills != 16'hFFFF)
            stat_refills <= stat_refills + 16'd1;
         if ((op_q == OP_WB || op_q == OP_WB_RD) && stat_writebacks != 16'hFFFF)
            stat_writebacks <= stat_writebacks + 16'd1;
      end
   end
`endif

endmodule
